// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported instruction/data memory between
// the IF fetch port and the MEM load/store port. Data requests have priority
// over fetch because they belong to the older instruction. A granted access is
// held until the memory acknowledges it. Per-port done pulses, read data and
// stall signals go back to the pipeline.
// Optional build macro FAIR_ARB_EN: adds a starve counter that forces a fetch
// grant after STARVE_LIMIT data grants made while fetch was waiting.
module unified_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    output logic              i_stall,
    // load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    // memory side
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                ram_req_q, ram_req_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_done_q, i_done_d;
    logic                d_done_q, d_done_d;

    logic                i_elig, d_elig;
    logic                grant_d, grant_i;

`ifdef FAIR_ARB_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                starve_hit;
`endif

    // Arbitration: a port that is completing this cycle is not eligible again,
    // so a held request is never re-granted in its own done cycle.
    always_comb begin
        i_elig = i_req & ~i_done_q;
        d_elig = d_req & ~d_done_q;
`ifdef FAIR_ARB_EN
        starve_hit = (starve_q == STARVE_W'(STARVE_LIMIT));
        grant_d    = d_elig & ~(starve_hit & i_elig);
`else
        grant_d    = d_elig;
`endif
        grant_i = i_elig & ~grant_d;
    end

    // Next-state and next-register values for the grant/complete FSM.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves one
        // unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
`ifdef FAIR_ARB_EN
        starve_d    = starve_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = D_BUSY;
                    ram_req_d   = 1'b1;
                    ram_we_d    = d_we;
                    ram_addr_d  = d_addr;
                    ram_wdata_d = d_wdata;
`ifdef FAIR_ARB_EN
                    // Saturate so the forced fetch grant stays pending.
                    if (i_req && !starve_hit)
                        starve_d = starve_q + STARVE_W'(1);
`endif
                end else if (grant_i) begin
                    state_d    = I_BUSY;
                    ram_req_d  = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = i_addr;
`ifdef FAIR_ARB_EN
                    starve_d   = '0;
`endif
                end
            end
            I_BUSY: begin
                if (ram_ack) begin
                    state_d   = IDLE;
                    ram_req_d = 1'b0;
                    i_done_d  = 1'b1;
                    i_rdata_d = ram_rdata;
                end
            end
            D_BUSY: begin
                if (ram_ack) begin
                    state_d   = IDLE;
                    ram_req_d = 1'b0;
                    d_done_d  = 1'b1;
                    // A store leaves the previous load data in place.
                    if (!ram_we_q)
                        d_rdata_d = ram_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: these are a handful of datapath registers, not a memory
            // array, so clearing them on reset is cheap and gives known outputs.
            state_q     <= IDLE;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
`ifdef FAIR_ARB_EN
            starve_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples the values
            // from before this edge, whatever the statement order.
            state_q     <= state_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
`ifdef FAIR_ARB_EN
            starve_q    <= starve_d;
`endif
        end
    end

    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;

    // Stalls are combinational so the hazard logic can freeze PC/IR this cycle.
    assign i_stall = rst & i_req & ~i_done_q;
    assign d_stall = rst & d_req & ~d_done_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_unified_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;
`ifdef FAIR_ARB_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_done, i_stall;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_done, d_stall;
    logic          ram_req, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          ram_ack = 1'b0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: one optional in-flight access plus the visible registers.
    bit          m_busy, m_is_data, m_we, m_i_done, m_d_done;
    logic [31:0] m_addr, m_wdata, m_i_rdata, m_d_rdata;
    int          m_starve;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_is_data = 0; m_we = 0; m_i_done = 0; m_d_done = 0;
        m_addr = '0; m_wdata = '0; m_i_rdata = '0; m_d_rdata = '0;
        m_starve = 0;
    endtask

    task automatic check_outputs();
        check("ram_req",   {31'b0, ram_req}, {31'b0, m_busy});
        check("ram_we",    {31'b0, ram_we},  {31'b0, m_we});
        check("ram_addr",  ram_addr,  m_addr);
        check("ram_wdata", ram_wdata, m_wdata);
        check("i_done",    {31'b0, i_done},  {31'b0, m_i_done});
        check("d_done",    {31'b0, d_done},  {31'b0, m_d_done});
        check("i_rdata",   i_rdata,   m_i_rdata);
        check("d_rdata",   d_rdata,   m_d_rdata);
        check("i_stall",   {31'b0, i_stall}, {31'b0, rst & i_req & ~m_i_done});
        check("d_stall",   {31'b0, d_stall}, {31'b0, rst & d_req & ~m_d_done});
    endtask

    // Advance one clock: predict from pre-edge inputs, check #1 after the edge,
    // then return at the falling edge so the caller can drive the next inputs.
    task automatic tick();
        bit          n_busy, n_is_data, n_we, n_i_done, n_d_done, ie, de, take_d;
        logic [31:0] n_addr, n_wdata, n_i_rdata, n_d_rdata;
        int          n_starve;
        n_busy = m_busy; n_is_data = m_is_data; n_we = m_we;
        n_addr = m_addr; n_wdata = m_wdata;
        n_i_rdata = m_i_rdata; n_d_rdata = m_d_rdata; n_starve = m_starve;
        n_i_done = 0; n_d_done = 0;
        ie = i_req && !m_i_done;
        de = d_req && !m_d_done;
        if (!m_busy) begin
            take_d = de && !(FAIR && ie && m_starve >= LIMIT);
            if (take_d) begin
                n_busy = 1; n_is_data = 1; n_we = d_we; n_addr = d_addr; n_wdata = d_wdata;
                if (i_req) n_starve = m_starve + 1;
            end else if (ie) begin
                n_busy = 1; n_is_data = 0; n_we = 0; n_addr = i_addr; n_starve = 0;
            end
        end else if (ram_ack) begin
            n_busy = 0;
            if (m_is_data) begin
                n_d_done = 1;
                if (!m_we) n_d_rdata = ram_rdata;
            end else begin
                n_i_done = 1;
                n_i_rdata = ram_rdata;
            end
        end
        @(posedge clk);
        #1;
        if (!rst) model_reset();
        else begin
            m_busy = n_busy; m_is_data = n_is_data; m_we = n_we;
            m_addr = n_addr; m_wdata = n_wdata;
            m_i_rdata = n_i_rdata; m_d_rdata = n_d_rdata;
            m_i_done = n_i_done; m_d_done = n_d_done; m_starve = n_starve;
        end
        check_outputs();
        @(negedge clk);
    endtask

    // Random requesters and memory: requests hold until done; a granted data
    // port scrambles its inputs to show they are ignored while busy.
    task automatic drive_random();
        ram_ack   = m_busy ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
        ram_rdata = $urandom();
        if (!i_req || m_i_done) begin
            i_req  = ($urandom_range(0, 9) < 6);
            i_addr = $urandom() & 32'h0000_0FFC;
        end
        if (!d_req || m_d_done) begin
            d_req   = ($urandom_range(0, 9) < 5);
            d_we    = ($urandom_range(0, 1) == 1);
            d_addr  = $urandom() & 32'h0000_0FFC;
            d_wdata = $urandom();
        end else if (m_busy && m_is_data) begin
            d_addr  = $urandom() & 32'h0000_0FFC;
            d_wdata = $urandom();
        end
    endtask

    initial begin
        // Reset state.
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        tick();
        rst = 1'b1;
        tick();

        // Reset in the middle of a stalled load.
        d_req = 1; d_we = 0; d_addr = 32'h40; ram_ack = 0;
        repeat (4) tick();
        check("mid_busy_ram_req", {31'b0, ram_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_ram_req_now", {31'b0, ram_req}, 32'd0);
        check_outputs();
        @(negedge clk);
        d_req = 0;
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_d_done", {31'b0, d_done}, 32'd0);

        // Single fetch with a zero-wait memory.
        i_req = 1; i_addr = 32'h100; ram_ack = 0;
        tick();
        check("fetch_ram_addr", ram_addr, 32'h100);
        check("fetch_ram_we", {31'b0, ram_we}, 32'd0);
        ram_ack = 1; ram_rdata = 32'h8C22_0004;
        tick();
        check("fetch_i_done", {31'b0, i_done}, 32'd1);
        check("fetch_i_rdata", i_rdata, 32'h8C22_0004);
        check("fetch_i_stall", {31'b0, i_stall}, 32'd0);
        i_req = 0; ram_ack = 0;
        tick();

        // Contention: store wins, its inputs change while busy, fetch follows.
        i_req = 1; i_addr = 32'h104;
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
        tick();
        check("cont_ram_we", {31'b0, ram_we}, 32'd1);
        check("cont_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        d_addr = 32'h300;
        tick();
        tick();
        check("busy_ram_addr_held", ram_addr, 32'h200);
        ram_ack = 1; ram_rdata = 32'h5555_AAAA;
        tick();
        check("cont_d_done", {31'b0, d_done}, 32'd1);
        d_req = 0; ram_ack = 0;
        tick();
        check("cont_fetch_addr", ram_addr, 32'h104);
        ram_ack = 1; ram_rdata = 32'h1234_5678;
        tick();
        check("cont_i_done", {31'b0, i_done}, 32'd1);
        i_req = 0; ram_ack = 0;
        tick();

        // Back-to-back loads on a held data request.
        d_req = 1; d_we = 0; d_addr = 32'h10; ram_ack = 1; ram_rdata = 32'h1111_1111;
        tick();
        tick();
        check("b2b_first_rdata", d_rdata, 32'h1111_1111);
        d_addr = 32'h14; ram_rdata = 32'h2222_2222;
        tick();
        check("b2b_no_regrant", {31'b0, ram_req}, 32'd0);
        tick();
        check("b2b_second_addr", ram_addr, 32'h14);
        tick();
        check("b2b_second_rdata", d_rdata, 32'h2222_2222);
        d_req = 0; ram_ack = 0;
        tick();

        // Both ports held continuously with zero-wait memory.
        i_req = 1; i_addr = 32'h180; d_req = 1; d_we = 0; d_addr = 32'h80; ram_ack = 1;
        for (int k = 0; k < 24; k++) begin
            ram_rdata = $urandom();
            tick();
        end
        i_req = 0; d_req = 0; ram_ack = 0;
        tick();
        tick();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            drive_random();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
